// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// The key map and column drive helper live here so the debouncer side can reuse them.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN = 2'b01,
    HOLD = 2'b10
  } state_t;

  // KEYMAP[row][col]; '*' reads as E and '#' as F
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] onehot_low_col(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-output signals of the scanner, bundled as one interface.
// master = the scanner; slave = the keypad matrix plus the downstream debouncer.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_pressed;

  modport master (
    input  rows,
    output cols,
    output key_code,
    output key_pressed
  );

  modport slave (
    output rows,
    input  cols,
    input  key_code,
    input  key_pressed
  );
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, parameterised width and reset value.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  // stage 0 may go metastable; stage 1 is the first usable value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner that locks onto one key at a time.
// Optional build macro KEYPAD_MULTI_REJECT_EN: ignore SCAN ticks with two or more rows low.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 48000
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [3:0]       rs;

  state_t     state, state_nxt;
  logic [1:0] col_idx, col_nxt;
  logic [1:0] lock_row, row_nxt;
  logic [3:0] key_code_q, code_nxt;
  logic       reject;

  logic [3:0] cols_o;
  logic       key_pressed_o;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (!v[i]) idx = 2'(i);
    return idx;
  endfunction

  sync_2ff #(
    .WIDTH   (4),
    .RST_VAL (4'b1111)
  ) u_rows_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kp.rows),
    .q     (rs)
  );

  // Columns only ever change on a tick, when the counter wraps anyway, so one
  // free-running counter also gives the restart-on-column-change behaviour.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

`ifdef KEYPAD_MULTI_REJECT_EN
  logic [3:0] lows;
  assign lows   = ~rs;
  assign reject = ((lows & (lows - 4'd1)) != 4'd0);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SCAN;
      col_idx    <= 2'd0;
      lock_row   <= 2'd0;
      key_code_q <= 4'h0;
    end else begin
      state      <= state_nxt;
      col_idx    <= col_nxt;
      lock_row   <= row_nxt;
      key_code_q <= code_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    row_nxt   = lock_row;
    code_nxt  = key_code_q;
    case (state)
      SCAN: begin
        if (tick) begin
          if (rs == 4'b1111 || reject) begin
            col_nxt = col_idx + 2'd1;
          end else begin
            row_nxt   = low_idx(rs);
            code_nxt  = KEYMAP[low_idx(rs)][col_idx];
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        // only the locked row matters; ghosts and rollover are ignored here
        if (tick && rs[lock_row]) begin
          state_nxt = SCAN;
          col_nxt   = col_idx + 2'd1;
        end
      end
      default: begin
        state_nxt = SCAN;
        col_nxt   = 2'd0;
        row_nxt   = 2'd0;
        code_nxt  = 4'h0;
      end
    endcase
  end

  always_comb begin
    cols_o        = onehot_low_col(col_idx);
    key_pressed_o = (state == HOLD);
  end

  assign kp.cols        = cols_o;
  assign kp.key_pressed = key_pressed_o;
  assign kp.key_code    = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed scenarios, random presses,
// and a cycle-level reference built from the scan/lock/release rules.
module tb_keypad_scanner;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  always #5 clk = ~clk;

  // held[r][c]: key at row r, column c is pressed
  logic [3:0] held [4];
  logic [3:0] phys_rows;
  always_comb begin
    phys_rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      phys_rows[r] = ~|(held[r] & ~kif.cols);
  end
  assign kif.rows = phys_rows;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [3:0] keytab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  int         m_cnt, m_col, m_r;
  bit         m_hold;
  logic [3:0] m_code, m_s1, m_s2;
  bit         reject_build;

  task automatic model_reset();
    m_cnt = 0; m_col = 0; m_r = 0; m_hold = 0;
    m_code = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF;
  endtask

  function automatic logic [3:0] m_cols();
    logic [3:0] v;
    v = 4'b1111;
    v[m_col] = 1'b0;
    return v;
  endfunction

  task automatic model_step();
    logic [3:0] rows_now, rs;
    int nlow, low;
    rs = m_s2;
    for (int r = 0; r < 4; r++) rows_now[r] = ~held[r][m_col];
    if (m_cnt == DIV - 1) begin
      nlow = 0; low = 0;
      for (int i = 3; i >= 0; i--) if (!rs[i]) begin nlow++; low = i; end
      if (!m_hold) begin
        if (nlow == 0 || (reject_build && nlow >= 2)) m_col = (m_col + 1) % 4;
        else begin
          m_r = low; m_code = keytab[low*4 + m_col]; m_hold = 1;
        end
      end else if (rs[m_r]) begin
        m_hold = 0; m_col = (m_col + 1) % 4;
      end
      m_cnt = 0;
    end else m_cnt++;
    m_s2 = m_s1; m_s1 = rows_now;
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
    chk("cols", kif.cols, m_cols());
    chk("key_pressed", kif.key_pressed, m_hold);
    chk("key_code", kif.key_code, m_code);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_kp(input logic want, input int max_cyc, input string tag);
    int n = 0;
    while (kif.key_pressed !== want && n < max_cyc) begin cyc(); n++; end
    chk(tag, kif.key_pressed, want);
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) held[r] = 4'b0000;
  endtask

  task automatic press_check(input int r, input int c, input logic [3:0] code, input string tag);
    held[r][c] = 1'b1;
    wait_kp(1'b1, 4*DIV + 3, {tag, "_press"});
    chk({tag, "_code"}, kif.key_code, code);
    held[r][c] = 1'b0;
    wait_kp(1'b0, DIV + 3, {tag, "_release"});
  endtask

  initial begin
`ifdef KEYPAD_MULTI_REJECT_EN
    reject_build = 1;
`else
    reject_build = 0;
`endif
    release_all();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_cols", kif.cols, 4'b1110);
    chk("rst_kp", kif.key_pressed, 1'b0);
    chk("rst_code", kif.key_code, 4'h0);
    reset = 1'b1;

    // idle rotation
    run(64);

    // hold '5'
    held[1][1] = 1'b1;
    wait_kp(1'b1, 4*DIV + 3, "t2_latency");
    chk("t2_code", kif.key_code, 4'h5);
    chk("t2_cols", kif.cols, 4'b1101);

    // rollover to '9' while '5' held
    held[2][2] = 1'b1;
    run(24);
    chk("t3_still5", kif.key_code, 4'h5);
    chk("t3_cols", kif.cols, 4'b1101);
    held[1][1] = 1'b0;
    wait_kp(1'b0, DIV + 3, "t3_release");
    wait_kp(1'b1, 4*DIV + 3, "t3_relatch");
    chk("t3_code9", kif.key_code, 4'h9);
    chk("t3_cols9", kif.cols, 4'b1011);
    held[2][2] = 1'b0;
    wait_kp(1'b0, DIV + 3, "t3_release9");
    run(10);

    // bottom row
    press_check(3, 0, 4'hE, "star");
    press_check(3, 2, 4'hF, "hash");
    press_check(3, 1, 4'h0, "zero");
    press_check(3, 3, 4'hD, "keyD");
    run(10);

    // '1' and '4' together in column 0
    held[0][0] = 1'b1;
    held[1][0] = 1'b1;
    if (reject_build) begin
      run(5*DIV);
      chk("t5_reject_kp", kif.key_pressed, 1'b0);
    end else begin
      wait_kp(1'b1, 4*DIV + 3, "t5_latch");
      chk("t5_code1", kif.key_code, 4'h1);
    end
    release_all();
    wait_kp(1'b0, DIV + 3, "t5_release");
    run(10);

    // random presses, sometimes with a second key
    for (int k = 0; k < 16; k++) begin
      int r, c;
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      held[r][c] = 1'b1;
      if ($urandom_range(0, 3) == 0) held[$urandom_range(0, 3)][$urandom_range(0, 3)] = 1'b1;
      run($urandom_range(10, 60));
      release_all();
      run($urandom_range(5, 40));
    end

    // asynchronous reset in the middle of HOLD
    held[1][1] = 1'b1;
    wait_kp(1'b1, 4*DIV + 3, "t6_press");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_cols", kif.cols, 4'b1110);
    chk("t6_rst_kp", kif.key_pressed, 1'b0);
    chk("t6_rst_code", kif.key_code, 4'h0);
    model_reset();
    release_all();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run(3*DIV);
    press_check(0, 3, 4'hA, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
